tmds_decoder: RTL and testbench



---
 rtl/tmds_pkg.sv | 57 +++++
 rtl/tmds_word_aligner.sv | 104 ++++++++++
 rtl/tmds_decoder.sv | 107 ++++++++++
 tb/tb_tmds_decoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions for the encoder and the receive-side decoder/checker.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Contents: the four control tokens, token -> {C1,C0} mapping, and the
// running-disparity decision used by both the encoder and the disparity checker.
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  // Outcome of one disparity step: whether the word goes out inverted
  // (w[9]) and the tracker value after that word.
  typedef struct packed {
    logic              invert;
    logic signed [7:0] cnt_next;
  } disp_t;

  function automatic logic is_token(input logic [9:0] w);
    return (w == TOKEN_C00) || (w == TOKEN_C01) ||
           (w == TOKEN_C10) || (w == TOKEN_C11);
  endfunction

  // Returns {C1, C0}; non-token words map to 00 and are never used as such.
  function automatic logic [1:0] token_ctrl(input logic [9:0] w);
    logic [1:0] c;
    c = 2'b00;
    if (w == TOKEN_C01) c = 2'b01;
    if (w == TOKEN_C10) c = 2'b10;
    if (w == TOKEN_C11) c = 2'b11;
    return c;
  endfunction

  // Encoder inversion rule. diff = N1 - N0 of q_m[7:0].
  function automatic disp_t disparity_step(input logic [8:0] q_m,
                                           input logic signed [7:0] cnt);
    disp_t             r;
    logic [3:0]        n1;
    logic signed [7:0] diff;
    n1 = 4'd0;
    for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, q_m[i]};
    diff = $signed({3'b000, n1, 1'b0}) - 8'sd8;
    if (cnt == 8'sd0 || diff == 8'sd0) begin
      r.invert   = ~q_m[8];
      r.cnt_next = q_m[8] ? (cnt + diff) : (cnt - diff);
    end else if ((cnt > 8'sd0 && diff > 8'sd0) || (cnt < 8'sd0 && diff < 8'sd0)) begin
      r.invert   = 1'b1;
      r.cnt_next = cnt + (q_m[8] ? 8'sd2 : 8'sd0) - diff;
    end else begin
      r.invert   = 1'b0;
      r.cnt_next = cnt - (q_m[8] ? 8'sd0 : 8'sd2) + diff;
    end
    return r;
  endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// Finds the 10-bit word boundary of a TMDS stream using control tokens.
// Latency: 1 cycle from window to word/token outputs; lock state updates on the same edge.
// Backpressure: none, one word accepted every clock.
// Ports: clk_i, rst_ni (sync, active-low), tmds_i raw word (bit 0 first);
//        word_o aligned word, token_o word is a control token,
//        locked_o alignment locked, offset_o current bit offset 0..9.
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS    = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [9:0] tmds_i,
  output logic [9:0] word_o,
  output logic       token_o,
  output logic       locked_o,
  output logic [3:0] offset_o
);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // One idle counter serves both timeouts, so size it for the larger one.
  localparam int IDLE_MAX = (LOSS_TIMEOUT > SEARCH_TIMEOUT) ? LOSS_TIMEOUT : SEARCH_TIMEOUT;
  localparam int RW = $clog2(LOCK_TOKENS) + 1;
  localparam int IW = $clog2(IDLE_MAX) + 1;
  localparam logic [RW-1:0] RUN_LIM  = RW'(LOCK_TOKENS);
  localparam logic [IW-1:0] SRCH_LIM = IW'(SEARCH_TIMEOUT);
  localparam logic [IW-1:0] LOSS_LIM = IW'(LOSS_TIMEOUT);

  logic [0:0]    state_q;
  logic [9:0]    prev_q;
  logic [3:0]    offset_q;
  logic [RW-1:0] run_q;
  logic [IW-1:0] idle_q;
  logic [19:0]   win;
  logic [9:0]    w_aligned;
  logic          tok;
  logic [3:0]    offset_next;

  // Older word sits in the low half, so offset 0 selects the previous word.
  assign win         = {tmds_i, prev_q};
  assign w_aligned   = win[{1'b0, offset_q} +: 10];
  assign tok         = is_token(w_aligned);
  assign offset_next = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_SEARCH;
      prev_q   <= '0;
      offset_q <= '0;
      run_q    <= '0;
      idle_q   <= '0;
      word_o   <= '0;
      token_o  <= 1'b0;
    end else begin
      prev_q  <= tmds_i;
      word_o  <= w_aligned;
      token_o <= tok;
      case (state_q)
        ST_SEARCH: begin
          // A token clears the idle count first, so it always beats a timeout.
          if (tok) begin
            idle_q <= '0;
            if (run_q + 1'b1 == RUN_LIM) begin
              state_q <= ST_LOCKED;
              run_q   <= '0;
            end else begin
              run_q <= run_q + 1'b1;
            end
          end else begin
            run_q <= '0;
            if (idle_q + 1'b1 == SRCH_LIM) begin
              idle_q   <= '0;
              offset_q <= offset_next;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end
        end
        default: begin
          // Only tokens at the locked offset are visible here; others look like data.
          if (tok) begin
            idle_q <= '0;
          end else if (idle_q + 1'b1 == LOSS_LIM) begin
            state_q  <= ST_SEARCH;
            idle_q   <= '0;
            run_q    <= '0;
            offset_q <= offset_next;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign locked_o = (state_q == ST_LOCKED);
  assign offset_o = offset_q;

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: word alignment plus 10b -> {C1,C0,DE,D[7:0]} decode.
// Latency: 2 cycles (aligned word register, then output register).
// Backpressure: none, one word per clock.
// Ports: clk_i, rst_ni (sync, active-low), tmds_i raw word (bit 0 first);
//        c0_o/c1_o control bits, de_o data enable, d_o data byte,
//        locked_o alignment locked, offset_o bit offset 0..9,
//        disparity_err_o (only with TMDS_DECODER_DISPARITY_CHECK_EN defined).
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS    = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [9:0] tmds_i,
  output logic       c0_o,
  output logic       c1_o,
  output logic       de_o,
  output logic [7:0] d_o,
  output logic       locked_o,
  output logic [3:0] offset_o
`ifdef TMDS_DECODER_DISPARITY_CHECK_EN
  ,
  output logic       disparity_err_o
`endif
);

  logic [9:0] word;
  logic       token;
  logic       aligned_locked;
  logic [7:0] q;
  logic [7:0] d_dec;

  tmds_word_aligner #(
    .LOCK_TOKENS   (LOCK_TOKENS),
    .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
    .LOSS_TIMEOUT  (LOSS_TIMEOUT)
  ) u_aligner (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .tmds_i  (tmds_i),
    .word_o  (word),
    .token_o (token),
    .locked_o(aligned_locked),
    .offset_o(offset_o)
  );

  // Undo the optional inversion, then the XOR/XNOR chain.
  always_comb begin
    q        = word[9] ? ~word[7:0] : word[7:0];
    d_dec    = '0;
    d_dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d_dec[i] = word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      c0_o     <= 1'b0;
      c1_o     <= 1'b0;
      de_o     <= 1'b0;
      d_o      <= '0;
      locked_o <= 1'b0;
    end else begin
      locked_o <= aligned_locked;
      if (!aligned_locked) begin
        c0_o <= 1'b0;
        c1_o <= 1'b0;
        de_o <= 1'b0;
        d_o  <= '0;
      end else if (token) begin
        {c1_o, c0_o} <= token_ctrl(word);
        de_o         <= 1'b0;
        d_o          <= '0;
      end else begin
        // Control bits keep the last token's value through the data period.
        de_o <= 1'b1;
        d_o  <= d_dec;
      end
    end
  end

`ifdef TMDS_DECODER_DISPARITY_CHECK_EN
  logic signed [7:0] disp_q;
  disp_t             d_step;

  assign d_step = disparity_step({word[8], q}, disp_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      disp_q          <= '0;
      disparity_err_o <= 1'b0;
    end else if (!aligned_locked || token) begin
      disp_q          <= '0;
      disparity_err_o <= 1'b0;
    end else begin
      // Track the encoder's own choice so one bad word yields one pulse.
      disp_q          <= d_step.cnt_next;
      disparity_err_o <= (d_step.invert != word[9]);
    end
  end
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
module tb_tmds_decoder;

  localparam int LT = 8;
  localparam int ST = 16;
  localparam int LS = 64;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] tmds = '0;
  logic       c0, c1, de, locked;
  logic [7:0] d;
  logic [3:0] offset;
  logic [10:0] outs;
`ifdef TMDS_DECODER_DISPARITY_CHECK_EN
  logic       derr;
`endif

  tmds_decoder #(
    .LOCK_TOKENS   (LT),
    .SEARCH_TIMEOUT(ST),
    .LOSS_TIMEOUT  (LS)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .tmds_i  (tmds),
    .c0_o    (c0),
    .c1_o    (c1),
    .de_o    (de),
    .d_o     (d),
    .locked_o(locked),
    .offset_o(offset)
`ifdef TMDS_DECODER_DISPARITY_CHECK_EN
    ,
    .disparity_err_o(derr)
`endif
  );

  always #5 clk = ~clk;

  assign outs = {c1, c0, de, d};

  typedef struct {
    logic [9:0]  w;
    logic [10:0] exp;  // {c1, c0, de, d}
  } vec_t;

  int         n_checks = 0;
  int         n_pass = 0;
  int         bias = 0;
  int         shift = 0;
  logic [9:0] last_w = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drives one word of the serial stream, delayed by 'shift' bits.
  task automatic step(input logic [9:0] w);
    logic [19:0] pair;
    pair   = {w, last_w};
    pair   = pair >> (10 - shift);
    tmds   = pair[9:0];
    last_w = w;
    @(posedge clk);
    #1;
  endtask

  // Reference TMDS encoder (DVI 1.0 flow), running disparity kept in 'bias'.
  function automatic logic [9:0] tmds_enc(input logic [7:0] din);
    logic [8:0] qm;
    logic [9:0] w;
    logic       use_xnor;
    int         n1d, n1, n0;
    n1d      = $countones(din);
    use_xnor = (n1d > 4) || (n1d == 4 && din[0] == 1'b0);
    qm[0]    = din[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ din[i]) : (qm[i-1] ^ din[i]);
    qm[8] = ~use_xnor;
    n1    = $countones(qm[7:0]);
    n0    = 8 - n1;
    if (bias == 0 || n1 == n0) begin
      w = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      if (qm[8]) bias = bias + n1 - n0;
      else       bias = bias + n0 - n1;
    end else if ((bias > 0 && n1 > n0) || (bias < 0 && n0 > n1)) begin
      w    = {1'b1, qm[8], ~qm[7:0]};
      bias = bias + (qm[8] ? 2 : 0) + n0 - n1;
    end else begin
      w    = {1'b0, qm[8], qm[7:0]};
      bias = bias - (qm[8] ? 0 : 2) + n1 - n0;
    end
    return w;
  endfunction

  vec_t vecs[7];

  initial begin
    int any_lock;

    // Reset state
    rst_n = 1'b0;
    step(10'h000);
    step(10'h000);
    check("reset_outs", 32'(outs), 32'h0);
    check("reset_locked", 32'(locked), 32'h0);
    check("reset_offset", 32'(offset), 32'h0);
`ifdef TMDS_DECODER_DISPARITY_CHECK_EN
    check("reset_derr", 32'(derr), 32'h0);
`endif
    rst_n = 1'b1;

    // Lock on aligned C00 tokens: the 8th token's output carries locked_o.
    for (int i = 0; i < LT; i++) step(T00);
    step(T00);
    check("lock_not_early", 32'(locked), 32'h0);
    step(T00);
    check("lock_aligned", 32'(locked), 32'h1);
    check("lock_offset", 32'(offset), 32'h0);
    check("lock_token_outs", 32'(outs), 32'h0);

    // Table: data then the other three tokens, each seen two words later.
    bias = 0;
    vecs[0] = '{tmds_enc(8'h00), {2'b00, 1'b1, 8'h00}};
    vecs[1] = '{tmds_enc(8'hFF), {2'b00, 1'b1, 8'hFF}};
    vecs[2] = '{tmds_enc(8'h55), {2'b00, 1'b1, 8'h55}};
    vecs[3] = '{tmds_enc(8'h10), {2'b00, 1'b1, 8'h10}};
    vecs[4] = '{T01, {2'b01, 1'b0, 8'h00}};
    vecs[5] = '{T10, {2'b10, 1'b0, 8'h00}};
    vecs[6] = '{T11, {2'b11, 1'b0, 8'h00}};
    for (int i = 0; i < 9; i++) begin
      step(i < 7 ? vecs[i].w : T11);
      if (i >= 2) begin
        check($sformatf("vec%0d_outs", i - 2), 32'(outs), 32'(vecs[i-2].exp));
`ifdef TMDS_DECODER_DISPARITY_CHECK_EN
        check($sformatf("vec%0d_derr", i - 2), 32'(derr), 32'h0);
`endif
      end
    end

`ifdef TMDS_DECODER_DISPARITY_CHECK_EN
    // One corrupted data word (w[9] toggled, w[7:0] inverted) -> one pulse.
    begin
      logic [7:0] bytes [5];
      logic [9:0] w;
      bytes = '{8'h10, 8'h55, 8'hA3, 8'h00, 8'hFF};
      step(T00);
      step(T00);
      bias = 0;
      for (int i = 0; i < 7; i++) begin
        if (i < 5) begin
          w = tmds_enc(bytes[i]);
          if (i == 2) w = w ^ 10'h2FF;
          step(w);
        end else begin
          step(T00);
        end
        if (i >= 2) begin
          check($sformatf("derr_word%0d", i - 2), 32'(derr), ((i - 2) == 2) ? 32'h1 : 32'h0);
          check($sformatf("derr_data%0d", i - 2), 32'(d), 32'(bytes[i-2]));
        end
      end
    end
`endif

    // Loss of lock after LS data-only cycles at the locked offset.
    step(T00);
    for (int k = 1; k <= LS + 2; k++) begin
      step(10'h100);
      if (k == LS + 1) check("loss_still_locked", 32'(locked), 32'h1);
      if (k == LS + 2) begin
        check("loss_unlocked", 32'(locked), 32'h0);
        check("loss_offset", 32'(offset), 32'h1);
      end
    end

    // Reset mid-stream while searching at offset 1.
    rst_n = 1'b0;
    step(10'h100);
    rst_n = 1'b1;
    check("midrst_outs", 32'(outs), 32'h0);
    check("midrst_locked", 32'(locked), 32'h0);
    check("midrst_offset", 32'(offset), 32'h0);

    // Stream shifted by 3 bits: offset steps every ST idle cycles, lock at 3.
    shift    = 3;
    last_w   = T00;
    any_lock = 0;
    for (int k = 1; k <= 57; k++) begin
      step(T00);
      if (k <= 56 && locked) any_lock++;
      if (k == 15) check("search_off_15", 32'(offset), 32'h0);
      if (k == 16) check("search_off_16", 32'(offset), 32'h1);
      if (k == 32) check("search_off_32", 32'(offset), 32'h2);
      if (k == 48) check("search_off_48", 32'(offset), 32'h3);
      if (k == 56) check("search_no_early_lock", 32'(any_lock), 32'h0);
      if (k == 57) begin
        check("search_locked", 32'(locked), 32'h1);
        check("search_lock_offset", 32'(offset), 32'h3);
        check("search_lock_outs", 32'(outs), 32'h0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
